// File: rtl/alien_hit_detector.sv
// Per-frame bullet-vs-formation collision scanner. Walks every alien slot once per
// frame, reports the first overlapping live alien as a kill over valid/ready.
module alien_hit_detector #(
  parameter int unsigned NUM_ROWS      = 3,
  parameter int unsigned NUM_COLUMNS   = 5,
  parameter int unsigned ALIEN_WIDTH   = 32,
  parameter int unsigned ALIEN_HEIGHT  = 16,
  parameter int unsigned BULLET_WIDTH  = 2,
  parameter int unsigned BULLET_HEIGHT = 8,
  localparam int unsigned RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int unsigned CW = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 frame_tick,
  input  logic                                 bullet_active,
  input  logic [15:0]                          bullet_x,
  input  logic [15:0]                          bullet_y,
  input  logic [NUM_ROWS-1:0][NUM_COLUMNS-1:0] alive_matrix,
  input  logic [15:0]                          alien_positions_x [NUM_ROWS-1:0][NUM_COLUMNS-1:0],
  input  logic [15:0]                          alien_positions_y [NUM_ROWS-1:0][NUM_COLUMNS-1:0],
  output logic                                 kill_valid,
  input  logic                                 kill_ready,
  output logic [RW-1:0]                        kill_row,
  output logic [CW-1:0]                        kill_col,
  output logic                                 bullet_hit,
  output logic                                 scan_done,
  output logic                                 busy
);

  localparam int unsigned POS_W = 16;
  localparam int unsigned SUM_W = POS_W + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_REPORT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [RW-1:0]    row_q, row_d;
  logic [CW-1:0]    col_q, col_d;
  logic             primed_q, primed_d;
  logic [POS_W-1:0] bx_q, bx_d;
  logic [POS_W-1:0] by_q, by_d;
  logic             kill_valid_q, kill_valid_d;
  logic [RW-1:0]    kill_row_q, kill_row_d;
  logic [CW-1:0]    kill_col_q, kill_col_d;
  logic             bullet_hit_q, bullet_hit_d;
  logic             scan_done_q, scan_done_d;
  logic             busy_q, busy_d;

  logic [SUM_W-1:0] ax_c, ay_c, bx_c, by_c;
  logic             overlap_c, hit_c, last_slot_c;

  // Box overlap for the current slot; 17-bit sums so edges near 0xFFFF never wrap.
  always_comb begin
    ax_c        = SUM_W'(alien_positions_x[row_q][col_q]);
    ay_c        = SUM_W'(alien_positions_y[row_q][col_q]);
    bx_c        = SUM_W'(bx_q);
    by_c        = SUM_W'(by_q);
    overlap_c   = (bx_c < ax_c + SUM_W'(ALIEN_WIDTH))
               && (bx_c + SUM_W'(BULLET_WIDTH) > ax_c)
               && (by_c < ay_c + SUM_W'(ALIEN_HEIGHT))
               && (by_c + SUM_W'(BULLET_HEIGHT) > ay_c);
    hit_c       = alive_matrix[row_q][col_q] && overlap_c;
    last_slot_c = (row_q == RW'(NUM_ROWS - 1)) && (col_q == CW'(NUM_COLUMNS - 1));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    primed_d     = primed_q;
    bx_d         = bx_q;
    by_d         = by_q;
    kill_row_d   = kill_row_q;
    kill_col_d   = kill_col_q;
    bullet_hit_d = 1'b0;
    scan_done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (frame_tick && bullet_active) begin
          bx_d     = bullet_x;
          by_d     = bullet_y;
          row_d    = '0;
          col_d    = '0;
          primed_d = 1'b0;
          state_d  = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // The first SCAN cycle only primes the walk, aligning slot k to edge k+1.
        if (!bullet_active) begin
          state_d = ST_IDLE;
        end else if (!primed_q) begin
          primed_d = 1'b1;
        end else if (hit_c) begin
          kill_row_d = row_q;
          kill_col_d = col_q;
          state_d    = ST_REPORT;
        end else if (last_slot_c) begin
          scan_done_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (col_q == CW'(NUM_COLUMNS - 1)) begin
          col_d = '0;
          row_d = row_q + RW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      ST_REPORT: begin
        if (kill_valid_q && kill_ready) begin
          bullet_hit_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    kill_valid_d = (state_d == ST_REPORT);
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      primed_q     <= 1'b0;
      bx_q         <= '0;
      by_q         <= '0;
      kill_valid_q <= 1'b0;
      kill_row_q   <= '0;
      kill_col_q   <= '0;
      bullet_hit_q <= 1'b0;
      scan_done_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      primed_q     <= primed_d;
      bx_q         <= bx_d;
      by_q         <= by_d;
      kill_valid_q <= kill_valid_d;
      kill_row_q   <= kill_row_d;
      kill_col_q   <= kill_col_d;
      bullet_hit_q <= bullet_hit_d;
      scan_done_q  <= scan_done_d;
      busy_q       <= busy_d;
    end
  end

  assign kill_valid = kill_valid_q;
  assign kill_row   = kill_row_q;
  assign kill_col   = kill_col_q;
  assign bullet_hit = bullet_hit_q;
  assign scan_done  = scan_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_alien_hit_detector.sv
// Self-checking bench for alien_hit_detector: directed scenarios plus randomized scans
// compared against a slot-by-slot box-overlap reference model.
module tb_alien_hit_detector;

  localparam int NR = 3;
  localparam int NC = 5;
  localparam int NS = NR * NC;
  localparam int AW = 32;
  localparam int AH = 16;
  localparam int BW = 2;
  localparam int BH = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              frame_tick;
  logic              bullet_active;
  logic [15:0]       bullet_x, bullet_y;
  logic [NR-1:0][NC-1:0] alive;
  logic [15:0]       pos_x [NR-1:0][NC-1:0];
  logic [15:0]       pos_y [NR-1:0][NC-1:0];
  logic              kill_valid, kill_ready;
  logic [1:0]        kill_row;
  logic [2:0]        kill_col;
  logic              bullet_hit, scan_done, busy;

  int n_cmp = 0;
  int n_err = 0;

  alien_hit_detector dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .frame_tick        (frame_tick),
    .bullet_active     (bullet_active),
    .bullet_x          (bullet_x),
    .bullet_y          (bullet_y),
    .alive_matrix      (alive),
    .alien_positions_x (pos_x),
    .alien_positions_y (pos_y),
    .kill_valid        (kill_valid),
    .kill_ready        (kill_ready),
    .kill_row          (kill_row),
    .kill_col          (kill_col),
    .bullet_hit        (bullet_hit),
    .scan_done         (scan_done),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: first live alien (row-major) whose box overlaps the bullet, else -1.
  function automatic int first_hit(input int bx, input int by);
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) begin
        int ax, ay;
        ax = int'(pos_x[r][c]);
        ay = int'(pos_y[r][c]);
        if (alive[r][c] && bx < ax + AW && bx + BW > ax && by < ay + AH && by + BH > ay)
          return r * NC + c;
      end
    return -1;
  endfunction

  task automatic set_grid();
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) begin
        pos_x[r][c] = 16'(100 + 64 * c);
        pos_y[r][c] = 16'(50 + 32 * r);
        alive[r][c] = 1'b1;
      end
  endtask

  // One full frame: tick, then check every cycle against the model's timeline.
  task automatic do_scan(input string tag, input logic [15:0] bx, input logic [15:0] by, input int rl);
    int k, h, last;
    k = first_hit(int'(bx), int'(by));
    h = (k >= 0) ? k + 3 + rl : -1;
    last = (k >= 0) ? h + 1 : NS + 2;
    bullet_x = bx;
    bullet_y = by;
    bullet_active = 1'b1;
    kill_ready = (rl == 0);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    for (int n = 0; n <= last; n++) begin
      if (k >= 0) begin
        chk($sformatf("%s.kv@%0d", tag, n), 32'(kill_valid), 32'(n >= k + 2 && n < h));
        chk($sformatf("%s.bh@%0d", tag, n), 32'(bullet_hit), 32'(n == h));
        chk($sformatf("%s.sd@%0d", tag, n), 32'(scan_done), 32'(0));
        chk($sformatf("%s.busy@%0d", tag, n), 32'(busy), 32'(n < h));
        if (n >= k + 2 && n < h) begin
          chk($sformatf("%s.row@%0d", tag, n), 32'(kill_row), 32'(k / NC));
          chk($sformatf("%s.col@%0d", tag, n), 32'(kill_col), 32'(k % NC));
        end
        kill_ready = (rl == 0) || (n >= k + 2 + rl);
        if (rl > 0 && n >= k + 2 && n < h) begin
          bullet_active = 1'($urandom_range(0, 1));
          frame_tick    = 1'($urandom_range(0, 1));
        end else begin
          bullet_active = 1'b1;
          frame_tick    = 1'b0;
        end
      end else begin
        chk($sformatf("%s.kv@%0d", tag, n), 32'(kill_valid), 32'(0));
        chk($sformatf("%s.bh@%0d", tag, n), 32'(bullet_hit), 32'(0));
        chk($sformatf("%s.sd@%0d", tag, n), 32'(scan_done), 32'(n == NS + 1));
        chk($sformatf("%s.busy@%0d", tag, n), 32'(busy), 32'(n <= NS));
      end
      step();
    end
    kill_ready = 1'b0;
    bullet_active = 1'b1;
    frame_tick = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    frame_tick = 1'b0;
    bullet_active = 1'b0;
    bullet_x = '0;
    bullet_y = '0;
    kill_ready = 1'b0;
    set_grid();
    step(); step(); step();
    chk("rst.kv", 32'(kill_valid), 32'(0));
    chk("rst.bh", 32'(bullet_hit), 32'(0));
    chk("rst.sd", 32'(scan_done), 32'(0));
    chk("rst.busy", 32'(busy), 32'(0));
    chk("rst.row", 32'(kill_row), 32'(0));
    chk("rst.col", 32'(kill_col), 32'(0));
    rst_n = 1'b1;
    step();

    // Tick without an active bullet does nothing.
    frame_tick = 1'b1;
    bullet_active = 1'b0;
    step();
    frame_tick = 1'b0;
    for (int n = 0; n < 4; n++) begin
      chk("noact.busy", 32'(busy), 32'(0));
      step();
    end

    do_scan("miss", 16'd10, 16'd400, 0);
    do_scan("hit12", 16'd240, 16'd90, 0);

    alive[2][2] = 1'b0;
    do_scan("dead22", 16'd240, 16'd120, 0);
    alive[2][2] = 1'b1;
    do_scan("live22", 16'd240, 16'd120, 0);
    alive[1][2] = 1'b0;
    do_scan("dead12", 16'd240, 16'd90, 0);
    set_grid();

    do_scan("edge260", 16'd260, 16'd90, 0);
    do_scan("edge259", 16'd259, 16'd90, 0);
    do_scan("xffff", 16'hFFFF, 16'd90, 0);
    pos_x[0][0] = 16'hFFF0;
    pos_y[0][0] = 16'd10;
    do_scan("top", 16'hFFF8, 16'd12, 0);
    set_grid();

    do_scan("bp3", 16'd240, 16'd90, 3);

    // Abort: bullet drops while slot 4 is under test.
    bullet_x = 16'd240;
    bullet_y = 16'd90;
    bullet_active = 1'b1;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    for (int n = 0; n <= 20; n++) begin
      chk($sformatf("abort.kv@%0d", n), 32'(kill_valid), 32'(0));
      chk($sformatf("abort.sd@%0d", n), 32'(scan_done), 32'(0));
      chk($sformatf("abort.bh@%0d", n), 32'(bullet_hit), 32'(0));
      chk($sformatf("abort.busy@%0d", n), 32'(busy), 32'(n <= 5));
      bullet_active = (n < 5);
      step();
    end
    bullet_active = 1'b1;

    // Reset while a kill is pending.
    kill_ready = 1'b0;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    for (int n = 0; n < 9; n++) step();
    chk("rstrep.kv_pre", 32'(kill_valid), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstrep.kv", 32'(kill_valid), 32'(0));
    chk("rstrep.busy", 32'(busy), 32'(0));
    step();
    rst_n = 1'b1;
    step();
    do_scan("after_rst", 16'd110, 16'd55, 0);

    for (int it = 0; it < 40; it++) begin
      int r, c, t;
      for (int rr = 0; rr < NR; rr++)
        for (int cc = 0; cc < NC; cc++) begin
          alive[rr][cc] = ($urandom_range(0, 9) != 0);
          if (it % 4 == 0) begin
            pos_x[rr][cc] = 16'($urandom_range(0, 65535));
            pos_y[rr][cc] = 16'($urandom_range(0, 65535));
          end else begin
            pos_x[rr][cc] = 16'(100 + 64 * cc);
            pos_y[rr][cc] = 16'(50 + 32 * rr);
          end
        end
      r = $urandom_range(0, NR - 1);
      c = $urandom_range(0, NC - 1);
      t = int'(pos_x[r][c]) + int'($urandom_range(0, 40)) - 8;
      if (t < 0) t = 0;
      if (t > 65535) t = 65535;
      bullet_x = 16'(t);
      t = int'(pos_y[r][c]) + int'($urandom_range(0, 24)) - 8;
      if (t < 0) t = 0;
      if (t > 65535) t = 65535;
      bullet_y = 16'(t);
      do_scan($sformatf("rnd%0d", it), bullet_x, bullet_y, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
